// File: rtl/de2_key_debouncer.sv
// de2_key_debouncer
//   Debounces and synchronises the raw DE2 pushbuttons before they reach the
//   keys PIO. Each key gets a 2-flop synchroniser and its own counter. A new
//   level is accepted only after DEBOUNCE_CYCLES consecutive synchronised
//   samples that differ from the current debounced level.
//
// Ports
//   clk          system clock, rising edge
//   reset        synchronous, active-high
//   key_n        raw pushbuttons, asynchronous, active-low
//   key_db_n     debounced level, active-low, registered (to PIO in_port)
//   key_press    one-cycle strobe on an accepted transition to pressed
//   key_release  one-cycle strobe on an accepted transition to released
//   key_any      high while any debounced key is pressed

// One debounce channel. The counter only runs while the synchronised input
// disagrees with the accepted level. A single agreeing sample clears it, so
// glitches shorter than DEBOUNCE_CYCLES samples never reach db_n.
module de2_key_debouncer_lane #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic sync_n,
  output logic db_n,
  output logic press,
  output logic rls
);
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      db_n  <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
      rls   <= 1'b0;
    end else begin
      press <= 1'b0;
      rls   <= 1'b0;
      if (sync_n == db_n) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        // This edge is the DEBOUNCE_CYCLES-th disagreeing sample, so accept it.
        // The counter saturates here and never wraps.
        db_n  <= sync_n;
        cnt   <= '0;
        press <= ~sync_n;
        rls   <= sync_n;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end
endmodule

module de2_key_debouncer #(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_n,
  output logic [NUM_KEYS-1:0] key_db_n,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic                key_any
);
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_param
    $error("de2_key_debouncer: DEBOUNCE_CYCLES must be >= 2");
  end

  // The synchroniser resets to the released level. A key held through reset
  // therefore looks like a fresh press once reset is removed.
  logic [NUM_KEYS-1:0] s1, s2;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= '1;
      s2 <= '1;
    end else begin
      s1 <= key_n;
      s2 <= s1;
    end
  end

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_lane
    de2_key_debouncer_lane #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_lane (
      .clk    (clk),
      .reset  (reset),
      .sync_n (s2[i]),
      .db_n   (key_db_n[i]),
      .press  (key_press[i]),
      .rls    (key_release[i])
    );
  end

  assign key_any = ~&key_db_n;
endmodule

// File: doc/de2_key_debouncer.md
# de2_key_debouncer

Debounces and synchronises the four raw DE2 pushbuttons (KEY[3:0], asynchronous, active-low, mechanically bouncing) before they reach the keys PIO. It sits directly upstream of the PIO's `in_port`. It outputs clean active-low levels, so the PIO's falling-edge capture sees exactly one edge per physical press. It also provides one-cycle press and release strobes and an any-key flag for local hardware use.

## Interface

**Parameters**
- `NUM_KEYS`, default 4: number of independent key channels.
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable synchronised samples needed to accept a new level (10 ms at 50 MHz). Must be ≥ 2.

**Ports**
- `clk`  in  1: system clock; all logic is on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `key_n`  in  NUM_KEYS: raw pushbutton inputs, asynchronous, active-low (0 = pressed).
- `key_db_n`  out  NUM_KEYS: debounced level, active-low, registered; connects to the PIO `in_port`.
- `key_press`  out  NUM_KEYS: one-cycle strobe, per key, when an accepted transition goes to pressed.
- `key_release`  out  NUM_KEYS: one-cycle strobe, per key, when an accepted transition goes to released.
- `key_any`  out  1: high while any `key_db_n` bit is 0; derived from registers only.

## Operation

**Synchroniser**
- Each key passes through a 2-flop synchroniser: `s1 <= key_n`, `s2 <= s1`. Both flops reset to 1.

**Per-key state**
- Debounced level `db[i]`, reset 1.
- Counter `cnt[i]`, width `$clog2(DEBOUNCE_CYCLES)`, reset 0.
- Each key channel is fully independent; there is no shared counter.

**Per-key update, every cycle when not in reset**
- `s2[i] == db[i]`: `cnt[i] <= 0`; strobes are 0.
- `s2[i] != db[i]` and `cnt[i] < DEBOUNCE_CYCLES-1`: `cnt[i] <= cnt[i]+1`.
- `s2[i] != db[i]` and `cnt[i] == DEBOUNCE_CYCLES-1`:
  - `db[i] <= s2[i]` and `cnt[i] <= 0`.
  - Registered strobe on the same edge: `key_press[i] <= 1` if `s2[i]==0`, otherwise `key_release[i] <= 1`.
- Strobes default to 0 on every other cycle, so each strobe lasts exactly one cycle.
- `key_db_n = db` and `key_any = ~&db`.

**Boundary conditions**
- Glitch rejection: any single synchronised sample equal to `db[i]` clears `cnt[i]`. An input shorter than `DEBOUNCE_CYCLES` stable samples never changes `db[i]`.
- No wrap-around: `cnt[i]` never exceeds `DEBOUNCE_CYCLES-1`.
- Simultaneous transitions on several keys produce multi-bit strobes in the same cycle.
- `key_press` and `key_release` are never high together for the same key.
- Reset mid-count discards all progress.
  - A key held pressed through reset is reported as a new press after the full latency from reset deassertion.
  - This press produces `key_press` and a falling edge on `key_db_n`.

## Timing

- Reset values: `key_db_n` = all 1, `key_press` = 0, `key_release` = 0, `key_any` = 0. These hold during the first cycle after `reset` is sampled high.
- Latency: suppose the raw `key_n[i]` change is first sampled by `s1` at edge 1 and then stays stable. Then `key_db_n[i]` and the strobe update at edge `DEBOUNCE_CYCLES+2`.
  - Edge 2 updates `s2`.
  - Edges 3 … `DEBOUNCE_CYCLES+2` count.
- Minimum time between accepted transitions on one key: `DEBOUNCE_CYCLES` cycles.
- Downstream PIO edge capture follows one cycle after its own double register. This block imposes no extra requirement on it.

## Test plan

All scenarios use `DEBOUNCE_CYCLES=4`.

1. Reset: hold `reset`=1 with `key_n`=4'h0 for 3 cycles -> `key_db_n`=4'hF, `key_press`=0, `key_release`=0, `key_any`=0 throughout.
2. Clean press: `key_n[0]` goes 1→0 just before edge 1 and is held -> `key_db_n`=4'hE at edge 6; `key_press`=4'b0001 for exactly one cycle; `key_any`=1.
3. Bounce: `key_n[1]` pattern low×3, high×1, then low held -> no change until 4 consecutive synchronised lows; `key_db_n[1]` falls exactly 6 edges after the final low begins; a single `key_press` pulse.
4. Release plus glitch: start with key0 pressed; apply high×2, low×1, then high held -> `key_db_n[0]` returns to 1 once only; `key_release`=4'b0001 for one cycle; `key_press` stays 0.
5. Simultaneous: keys 2 and 3 pressed on the same cycle -> `key_press`=4'b1100 for one cycle; `key_db_n`=4'h3.
6. Reset mid-count: key0 held low, assert `reset` when `cnt[0]`=2, deassert it, keep key0 low -> `key_db_n[0]` falls 6 edges after the first post-reset sample; one `key_press` pulse.
